// File: rtl/rv_pbus_master_if.sv
// Host-side command/data streams and peripheral memory-access bus
// grouped for rv_pbus_master. The master modport is the burst initiator.
interface rv_pbus_master_if #(
  parameter int LENW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [31:0]     cmd_adr;
  logic [LENW-1:0] cmd_len;
  logic            wd_valid;
  logic            wd_ready;
  logic [31:0]     wd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [31:0]     rd_data;
  logic            done;
  logic            err;
  logic [31:0]     p_adr;
  logic            p_we;
  logic            p_re;
  logic [31:0]     p_dw;
  logic [31:0]     p_dr;
  logic            p_ack;

  modport master (
    input  cmd_valid, cmd_write, cmd_adr, cmd_len, wd_valid, wd_data,
           rd_ready, p_dr, p_ack,
    output cmd_ready, wd_ready, rd_valid, rd_data, done, err,
           p_adr, p_we, p_re, p_dw
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_adr, cmd_len, wd_valid, wd_data,
           rd_ready, p_dr, p_ack,
    input  cmd_ready, wd_ready, rd_valid, rd_data, done, err,
           p_adr, p_we, p_re, p_dw
  );
endinterface

// File: rtl/rv_pbus_master.sv
// Burst initiator for the peripheral memory-access bus. Accepts one
// command, performs one strobe/ack access per word, streams write data in
// and read data out, and aborts with a sticky err when no ack arrives
// within TIMEOUT strobe cycles. Every output is a flop; the output flags
// are loaded from the state being entered so they line up with that state.
module rv_pbus_master #(
  parameter int TIMEOUT = 64,
  parameter int LENW    = 8
) (
  input  logic             cclk,
  input  logic             reset,
  rv_pbus_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WFETCH = 3'd1,
    ACCESS = 3'd2,
    RHOLD  = 3'd3,
    GAP    = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [LENW-1:0] cnt_r, cnt_s;     // words remaining after the current one
  logic [TW-1:0]   tmo_r, tmo_s;     // strobe cycles elapsed without ack
  logic            dir_r, dir_s;     // 1 = write burst
  logic [31:0]     adr_r, adr_s;
  logic [31:0]     dw_r, dw_s;
  logic [31:0]     rdat_r, rdat_s;
  logic            err_r, err_s;
  logic            last_s;
  logic            cmd_ready_r, wd_ready_r, rd_valid_r, done_r, p_we_r, p_re_r;

  // Next-state and datapath decisions for the burst sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tmo_s   = tmo_r;
    dir_s   = dir_r;
    adr_s   = adr_r;
    dw_s    = dw_r;
    rdat_s  = rdat_r;
    err_s   = err_r;
    last_s  = (cnt_r == {LENW{1'b0}});
    case (state_r)
      IDLE: begin
        // cmd_ready_r is low only in the first cycle after reset release
        if (bus.cmd_valid && cmd_ready_r) begin
          adr_s   = bus.cmd_adr & 32'hFFFF_FFFC;
          cnt_s   = bus.cmd_len;
          dir_s   = bus.cmd_write;
          err_s   = 1'b0;
          tmo_s   = {TW{1'b0}};
          state_s = bus.cmd_write ? WFETCH : ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      WFETCH: begin
        if (bus.wd_valid) begin
          dw_s    = bus.wd_data;
          tmo_s   = {TW{1'b0}};
          state_s = ACCESS;
        end else begin
          state_s = WFETCH;
        end
      end
      ACCESS: begin
        if (bus.p_ack) begin
          if (dir_r) begin
            state_s = last_s ? FIN : GAP;
          end else begin
            rdat_s  = bus.p_dr;
            state_s = RHOLD;
          end
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          // This was the last permitted strobe cycle: abort the burst
          err_s   = 1'b1;
          state_s = FIN;
        end else begin
          tmo_s   = tmo_r + TW'(1);
        end
      end
      RHOLD: begin
        if (bus.rd_ready) begin
          state_s = last_s ? FIN : GAP;
        end else begin
          state_s = RHOLD;
        end
      end
      GAP: begin
        adr_s   = adr_r + 32'd4;
        cnt_s   = cnt_r - LENW'(1);
        tmo_s   = {TW{1'b0}};
        state_s = dir_r ? WFETCH : ACCESS;
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; flags follow the state being entered.
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {LENW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      dir_r       <= 1'b0;
      adr_r       <= 32'h0000_0000;
      dw_r        <= 32'h0000_0000;
      rdat_r      <= 32'h0000_0000;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b0;
      wd_ready_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      p_we_r      <= 1'b0;
      p_re_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      dir_r       <= dir_s;
      adr_r       <= adr_s;
      dw_r        <= dw_s;
      rdat_r      <= rdat_s;
      err_r       <= err_s;
      cmd_ready_r <= (state_s == IDLE);
      wd_ready_r  <= (state_s == WFETCH);
      rd_valid_r  <= (state_s == RHOLD);
      done_r      <= (state_s == FIN);
      p_we_r      <= (state_s == ACCESS) && dir_s;
      p_re_r      <= (state_s == ACCESS) && !dir_s;
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.wd_ready  = wd_ready_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rdat_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.p_adr     = adr_r;
  assign bus.p_we      = p_we_r;
  assign bus.p_re      = p_re_r;
  assign bus.p_dw      = dw_r;

endmodule

// File: tb/tb_rv_pbus_master.sv
// Self-checking bench for rv_pbus_master. A bench-side responder acks
// after a random delay and returns address ^ 0xA5A5A5A5 on reads; expected
// addresses, data, handshake counts and cycle timing are derived from the
// burst command with plain arithmetic.
module tb_rv_pbus_master;

  localparam int TMO = 16;

  logic  cclk  = 1'b0;
  logic  reset = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string cur    = "init";

  rv_pbus_master_if #(.LENW(8)) bus ();

  rv_pbus_master #(.TIMEOUT(TMO), .LENW(8)) dut (
    .cclk  (cclk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", cur, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
    cyc++;
  endtask

  task automatic chk_quiet(input logic exp_cmd_ready);
    chk("cmd_ready", bus.cmd_ready, exp_cmd_ready);
    chk("wd_ready", bus.wd_ready, 0);
    chk("rd_valid", bus.rd_valid, 0);
    chk("rd_data", bus.rd_data, 0);
    chk("done", bus.done, 0);
    chk("err", bus.err, 0);
    chk("p_adr", bus.p_adr, 0);
    chk("p_we", bus.p_we, 0);
    chk("p_re", bus.p_re, 0);
    chk("p_dw", bus.p_dw, 0);
  endtask

  // fail_idx >= 0: responder never acks that word. rd_hold: rd_ready held
  // low for that many rd_valid cycles of each word.
  task automatic run_burst(input string name, input logic wr, input logic [31:0] adr,
                           input int len, input logic [31:0] wd0, input int dmin,
                           input int dmax, input int fail_idx, input int rdy_pct,
                           input int wdv_pct, input int rd_hold);
    logic [31:0] eadr [$];
    logic [31:0] wdat [$];
    logic [31:0] base, cur_adr, cur_dw;
    int nw, exp_acc, exp_wd, exp_rd, ai, wi, ri, held, dly, budget;
    int ack_cyc, wd_cyc, rd_cyc, acc_cyc, drop_cyc, rdv_cnt;
    logic str, prev_str, prev_ack, ack_now, hs_wd, hs_rd, done_seen;
    cur = name;
    nw = len + 1;
    base = adr & 32'hFFFF_FFFC;
    for (int i = 0; i < nw; i++) begin
      eadr.push_back(base + 32'(4 * i));
      wdat.push_back((i == 0) ? wd0 : $urandom);
    end
    exp_acc = (fail_idx >= 0) ? fail_idx + 1 : nw;
    exp_wd  = wr ? exp_acc : 0;
    exp_rd  = wr ? 0 : ((fail_idx >= 0) ? fail_idx : nw);

    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_adr   = adr;
    bus.cmd_len   = 8'(len);
    acc_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = $urandom;
    chk("err_clear", bus.err, 0);

    ai = 0; wi = 0; ri = 0; held = 0; dly = 0; budget = 0; rdv_cnt = 0;
    ack_cyc = -100; wd_cyc = -100; rd_cyc = -100; drop_cyc = -100;
    prev_str = 1'b0; prev_ack = 1'b0; done_seen = 1'b0;
    cur_adr = 32'h0; cur_dw = 32'h0;
    while (!done_seen && budget < 3000) begin
      budget++;
      str = bus.p_we | bus.p_re;
      if (str) chk("strobe_excl", bus.p_we & bus.p_re, 0);
      if (prev_ack) chk("strobe_low_after_ack", str, 0);
      if (str && !prev_str) begin
        chk("access_bound", ai < exp_acc, 1);
        if (ai < exp_acc) begin
          chk("p_adr", bus.p_adr, eadr[ai]);
          chk("dir", bus.p_we, wr);
          if (wr) begin
            chk("p_dw", bus.p_dw, wdat[ai]);
            chk("wr_strobe_lat", cyc, wd_cyc + 1);
          end else if (ai == 0) begin
            chk("rd_strobe_lat", cyc, acc_cyc + 1);
          end
        end
        if (ai > 0) begin
          chk("gap_min", (cyc - ack_cyc) >= 2, 1);
          if ((wr ? wdv_pct : rdy_pct) == 100 && rd_hold == 0)
            chk("gap_streaming", cyc - ack_cyc, 3);
        end
        ai++;
        held = 1;
        cur_adr = bus.p_adr;
        cur_dw  = bus.p_dw;
        dly = (ai - 1 == fail_idx) ? 1000000 : $urandom_range(dmax, dmin);
      end else if (str) begin
        held++;
        chk("p_adr_stable", bus.p_adr, cur_adr);
        chk("p_dw_stable", bus.p_dw, cur_dw);
      end
      if (!str && prev_str && !prev_ack) begin
        drop_cyc = cyc;
        chk("tmo_word", ai - 1, fail_idx);
        chk("tmo_len", held, TMO);
        chk("tmo_err", bus.err, 1);
        chk("tmo_done", bus.done, 1);
      end
      if (bus.rd_valid) begin
        rdv_cnt++;
        chk("no_strobe_in_rd", str, 0);
        chk("rd_bound", ri < exp_rd, 1);
        if (ri < exp_rd) chk("rd_data", bus.rd_data, eadr[ri] ^ 32'hA5A5A5A5);
      end else begin
        rdv_cnt = 0;
      end
      if (bus.done) begin
        done_seen = 1'b1;
        if (fail_idx >= 0) chk("done_at_abort", cyc, drop_cyc);
        else if (wr)       chk("done_lat_wr", cyc, ack_cyc + 1);
        else               chk("done_lat_rd", cyc, rd_cyc + 1);
        chk("err_final", bus.err, fail_idx >= 0);
      end

      ack_now = str && (held == dly + 1);
      bus.p_ack = ack_now | (!str && ($urandom_range(9, 0) == 0));
      bus.p_dr  = ack_now ? (cur_adr ^ 32'hA5A5A5A5) : $urandom;
      if (ack_now) ack_cyc = cyc;
      bus.wd_valid = ($urandom_range(99, 0) < wdv_pct);
      bus.wd_data  = (wi < nw) ? wdat[wi] : $urandom;
      if (bus.rd_valid && rd_hold > 0 && rdv_cnt <= rd_hold) bus.rd_ready = 1'b0;
      else bus.rd_ready = ($urandom_range(99, 0) < rdy_pct);
      hs_wd = bus.wd_valid & bus.wd_ready;
      hs_rd = bus.rd_valid & bus.rd_ready;
      if (hs_wd) begin
        wd_cyc = cyc;
        chk("wd_bound", wi < exp_wd, 1);
      end
      if (hs_rd) rd_cyc = cyc;
      prev_str = str;
      prev_ack = ack_now;
      tick();
      if (hs_wd) wi++;
      if (hs_rd) ri++;
    end

    chk("done_seen", done_seen, 1);
    chk("access_count", ai, exp_acc);
    chk("wd_count", wi, exp_wd);
    chk("rd_count", ri, exp_rd);
    chk("done_single", bus.done, 0);
    chk("cmd_ready_after_done", bus.cmd_ready, 1);
    chk("err_sticky", bus.err, fail_idx >= 0);
    bus.p_ack    = 1'b0;
    bus.wd_valid = 1'b0;
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_len   = 8'h0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = 32'h0;
    bus.rd_ready  = 1'b0;
    bus.p_dr      = 32'h0;
    bus.p_ack     = 1'b0;

    // Reset state, then release
    cur = "reset";
    tick();
    tick();
    chk_quiet(1'b0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_release", bus.cmd_ready, 1);

    // Directed scenarios
    run_burst("single_write", 1'b1, 32'h0000_0100, 0, 32'hDEAD_BEEF, 2, 2, -1, 100, 100, 0);
    run_burst("read_burst", 1'b0, 32'h0000_0200, 3, 32'h0, 0, 0, -1, 100, 100, 0);
    run_burst("backpressure", 1'b0, 32'h0000_0400, 1, 32'h0, 0, 1, -1, 100, 100, 10);
    run_burst("wrap_write", 1'b1, 32'hFFFF_FFFD, 1, 32'h0BAD_F00D, 0, 1, -1, 100, 100, 0);
    run_burst("wr_stream", 1'b1, 32'h0000_0800, 3, 32'h1111_2222, 0, 0, -1, 100, 100, 0);
    run_burst("timeout_rd", 1'b0, 32'h0000_0500, 0, 32'h0, 0, 0, 0, 100, 100, 0);
    run_burst("after_tmo", 1'b0, 32'h0000_0600, 1, 32'h0, 0, 2, -1, 100, 100, 0);
    run_burst("timeout_wr", 1'b1, 32'h0000_0700, 3, 32'h5555_AAAA, 0, 1, 1, 100, 100, 0);

    // Random bursts
    for (int k = 0; k < 10; k++)
      run_burst("random", 1'($urandom_range(1, 0)), $urandom, $urandom_range(5, 0), $urandom,
                0, 3, -1, $urandom_range(100, 30), $urandom_range(100, 30), 0);
    run_burst("rand_tmo", 1'($urandom_range(1, 0)), $urandom, 4, $urandom,
              0, 2, $urandom_range(4, 0), 80, 80, 0);

    // Reset in the middle of an access of a 4-word write
    cur = "reset_mid";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_adr   = 32'h0000_0300;
    bus.cmd_len   = 8'd3;
    bus.p_ack     = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.wd_valid  = 1'b1;
    bus.wd_data   = 32'h1234_5678;
    for (int i = 0; i < 10 && !bus.p_we; i++) tick();
    bus.wd_valid = 1'b0;
    tick();
    tick();
    chk("strobe_held", bus.p_we, 1);
    #3 reset = 1'b1;
    #1;
    chk_quiet(1'b0);
    tick();
    chk("no_done_in_reset", bus.done, 0);
    chk("cmd_ready_in_reset", bus.cmd_ready, 0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);
    run_burst("write_after_reset", 1'b1, 32'h0000_0340, 0, 32'hCAFE_F00D, 1, 1, -1, 100, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_pbus_master.md
# rv_pbus_master

Burst initiator for the core's peripheral memory-access bus (p_adr/p_we/p_re/p_dw/p_dr/p_ack). Lets a host-side agent (loader, debug bridge, DMA) write program/data words into, or read them out of, core memory. Accepts one burst command at a time, streams write data in or read data out through valid/ready ports, runs one bus access per word, and aborts with an error flag when the responder fails to acknowledge within a cycle budget.

## Interface
- TIMEOUT, 64: max cycles a strobe is held without p_ack before abort (≥2)
- LENW, 8: width of burst length field; burst = cmd_len+1 words
- cclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_adr  in  32  start byte address; bits [1:0] ignored (forced 0)
- cmd_len  in  LENW  words minus one
- wd_valid  in  1  write word offered
- wd_ready  out  1  write word taken when both high
- wd_data  in  32  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  read word taken when both high
- rd_data  out  32  read word
- done  out  1  one-cycle pulse at burst end (normal or aborted)
- err  out  1  sticky timeout flag; cleared on next command accept
- p_adr  out  32  bus address
- p_we  out  1  write strobe
- p_re  out  1  read strobe
- p_dw  out  32  bus write data
- p_dr  in  32  bus read data, valid in p_ack cycle
- p_ack  in  1  single-cycle access acknowledge

## Operation
- All outputs registered. Reset (async, any time, including mid-burst): state IDLE, every output 0 except cmd_ready=1 after reset releases (cmd_ready is 0 while reset high); counters cleared; in-flight access dropped, no done pulse.
- States: IDLE, WFETCH, ACCESS, RHOLD, GAP, FIN.
- IDLE: cmd_ready=1. On accept: latch adr&~3, len, dir; clear err; go WFETCH (write) or ACCESS (read).
- WFETCH: wd_ready=1; on wd_valid: latch p_dw, go ACCESS.
- ACCESS: p_we or p_re held high with stable p_adr/p_dw until p_ack. On p_ack: read → capture p_dr into rd_data, go RHOLD; write → go GAP (or FIN if last word). Timeout counter increments each ACCESS cycle without ack; reaching TIMEOUT → deassert strobe, set err, go FIN (remaining write words are not consumed; no rd_valid for the failed word).
- RHOLD: rd_valid=1; on rd_ready: go GAP (or FIN if last word).
- GAP: strobes low one cycle; p_adr += 4 (32-bit wrap, 0xFFFFFFFC→0x0); word counter decrements; go WFETCH or ACCESS.
- FIN: done=1 for one cycle, return IDLE.
- p_ack outside ACCESS is ignored. p_we and p_re never both high.

## Timing
- Command accept at cycle 0 → read strobe high cycle 1; write: wd_ready high cycle 1, strobe high cycle after wd handshake.
- p_ack at cycle n: strobe low at n+1; read rd_valid at n+1; next strobe no earlier than n+2 (write with wd_valid already high: wd taken n+2, strobe n+3; read with rd_ready high at n+1: strobe n+3).
- Zero-wait responder (ack in first strobe cycle): read burst throughput 1 word / 3 cycles with rd_ready tied high.
- Last word: done asserted one cycle after final ack (write) or final rd handshake (read); cmd_ready high the cycle after done.
- Timeout: strobe high exactly TIMEOUT cycles, low next cycle with err=1 and done=1 together, err stays 1.

## Test plan
- Single write, cmd_adr=0x100, len=0, wd=0xDEADBEEF, ack after 2 cycles → one p_we period with p_adr=0x100, p_dw=0xDEADBEEF; done 1 cycle after ack; err=0.
- Read burst adr=0x200 len=3, responder returns adr^0xA5A5A5A5 → p_adr 0x200,0x204,0x208,0x20C; rd_data sequence matches; exactly 4 rd_valid handshakes, one done.
- Backpressure: read burst len=1 with rd_ready low 10 cycles → rd_data stable, no second p_re until rd handshake.
- Wrap: write adr=0xFFFFFFFD len=1 → p_adr 0xFFFFFFFC then 0x00000000.
- Timeout: TIMEOUT=16, no ack → p_re high 16 cycles, then err=1, done pulse; next command clears err and completes normally.
- Reset asserted mid-ACCESS of a 4-word write → outputs 0 immediately, no done; after release a new 1-word write completes correctly.
